// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-address generator.
package pc_gen_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] ZERO_WORD  = 32'h0;

  // Redirect source indices; lower index means older stage and higher priority.
  localparam int unsigned REDIR_EX = 0;
  localparam int unsigned REDIR_ID = 1;

  // Width of a redirect source index, never less than one bit.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect, BTB update and fetch PC bundle between the pipeline and pc_gen.
interface pc_gen_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REDIR = 2
);

  logic                        stall_i;
  logic [NUM_REDIR-1:0]        redir_valid_i;
  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i;
  logic                        upd_valid_i;
  logic [ADDR_W-1:0]           upd_pc_i;
  logic [ADDR_W-1:0]           upd_target_i;
  logic                        upd_taken_i;
  logic [ADDR_W-1:0]           pc_o;
  logic                        redir_o;
  logic                        pred_taken_o;

  modport master (
    output stall_i, redir_valid_i, redir_addr_i,
    output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    input  pc_o, redir_o, pred_taken_o
  );

  modport slave (
    input  stall_i, redir_valid_i, redir_addr_i,
    input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
    output pc_o, redir_o, pred_taken_o
  );

endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one update per cycle,
// valid bits cleared by reset. Updates become visible the following cycle.
module pc_gen_btb #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i
);

  localparam int unsigned Entries = 1 << BTB_IDX_W;
  localparam int unsigned TagW    = ADDR_W - BTB_IDX_W - 2;

  logic [Entries-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q    [Entries];
  logic [TagW-1:0]    tag_d    [Entries];
  logic [ADDR_W-1:0]  target_q [Entries];
  logic [ADDR_W-1:0]  target_d [Entries];

  logic [BTB_IDX_W-1:0] lk_idx, upd_idx;
  logic [TagW-1:0]      lk_tag, upd_tag;
  logic [3:0]           unused_low_bits;

  assign lk_idx          = lookup_pc_i[BTB_IDX_W+1:2];
  assign lk_tag          = lookup_pc_i[ADDR_W-1:BTB_IDX_W+2];
  assign upd_idx         = upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag         = upd_pc_i[ADDR_W-1:BTB_IDX_W+2];
  assign unused_low_bits = {lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target_o = target_q[lk_idx];

  // Taken resolution installs the entry; not-taken evicts only the matching branch.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
      end else if (valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag)) begin
        valid_d[upd_idx] = 1'b0;
      end
    end
  end

  // Only valid bits need reset; tag/target are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and target storage.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, fixed-priority redirects with a pending
// slot that survives stalls, and an optional BTB enabled by PC_GEN_BTB_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      NUM_REDIR = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned      BTB_IDX_W = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam int unsigned SrcW = src_width(NUM_REDIR);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redir_q, redir_d;
  logic              pend_v_q, pend_v_d;
  logic [SrcW-1:0]   pend_src_q, pend_src_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              live_v;
  logic [SrcW-1:0]   live_idx;
  logic [ADDR_W-1:0] live_addr;
  logic              take_live;
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  logic [ADDR_W-1:0] pred_next;

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (pc_q),
    .hit_o        (btb_hit),
    .target_o     (btb_target),
    .upd_valid_i  (bus.upd_valid_i),
    .upd_pc_i     (bus.upd_pc_i),
    .upd_target_i (bus.upd_target_i),
    .upd_taken_i  (bus.upd_taken_i)
  );
`else
  logic unused_upd;
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
  assign unused_upd = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_target_i, bus.upd_taken_i};
`endif

  // Lowest-index live request wins; scan downward so the last hit is the lowest.
  always_comb begin
    live_v   = 1'b0;
    live_idx = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (bus.redir_valid_i[k]) begin
        live_v   = 1'b1;
        live_idx = SrcW'(k);
      end
    end
  end

  assign live_addr = bus.redir_addr_i[int'(live_idx)*ADDR_W +: ADDR_W];
  // Equal index takes the live one so a newer redirect replaces an older one.
  assign take_live = live_v && (!pend_v_q || (live_idx <= pend_src_q));
  assign pred_next = btb_hit ? btb_target : pc_q + ADDR_W'(INST_BYTES);

  // Next-state for PC, flush marker and the pending redirect slot.
  always_comb begin
    pc_d        = pc_q;
    redir_d     = 1'b0;
    pend_v_d    = pend_v_q;
    pend_src_d  = pend_src_q;
    pend_addr_d = pend_addr_q;
    if (bus.stall_i) begin
      if (take_live) begin
        pend_v_d    = 1'b1;
        pend_src_d  = live_idx;
        pend_addr_d = live_addr;
      end
    end else if (take_live || pend_v_q) begin
      pc_d     = take_live ? live_addr : pend_addr_q;
      redir_d  = 1'b1;
      pend_v_d = 1'b0;
    end else begin
      pc_d = pred_next;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      redir_q     <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_src_q  <= '0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      pend_v_q    <= pend_v_d;
      pend_src_q  <= pend_src_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.redir_o      = redir_q;
  assign bus.pred_taken_o = btb_hit;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues the expected registered outputs
// for each cycle it drives; the monitor pops and compares after every clock edge.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst;

  pc_gen_if #(.ADDR_W(32), .NUM_REDIR(2)) bus ();

  pc_gen #(
    .ADDR_W    (32),
    .NUM_REDIR (2),
    .RESET_PC  (32'h0),
    .BTB_IDX_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        r;
    logic        p;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: the design updates every cycle, so each edge with a queued entry is checked.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.pc_o !== e.pc || bus.redir_o !== e.r || bus.pred_taken_o !== e.p) begin
        n_fail++;
        $display("FAIL %s: got pc=%h redir=%b pred=%b, expected pc=%h redir=%b pred=%b",
                 e.name, bus.pc_o, bus.redir_o, bus.pred_taken_o, e.pc, e.r, e.p);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after its edge.
  task automatic cyc(input logic st, input logic [1:0] rv, input logic [31:0] a0,
                     input logic [31:0] a1, input logic rs, input logic [31:0] epc,
                     input logic er, input logic ep, input string nm,
                     input logic uv = 1'b0, input logic [31:0] upc = 32'h0,
                     input logic [31:0] utg = 32'h0, input logic utk = 1'b0);
    exp_t x;
    @(negedge clk);
    rst               = rs;
    bus.stall_i       = st;
    bus.redir_valid_i = rv;
    bus.redir_addr_i  = {a1, a0};
    bus.upd_valid_i   = uv;
    bus.upd_pc_i      = upc;
    bus.upd_target_i  = utg;
    bus.upd_taken_i   = utk;
    x.pc   = epc;
    x.r    = er;
    x.p    = ep;
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.stall_i       = 1'b0;
    bus.redir_valid_i = '0;
    bus.redir_addr_i  = '0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = '0;
    bus.upd_target_i  = '0;
    bus.upd_taken_i   = 1'b0;

    //  st  rv     a0            a1            rst   pc            r     p
    cyc(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        0, 0, "reset_0");
    cyc(0, 2'b00, 32'h0,        32'h0,        1, 32'h0,        0, 0, "reset_1");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h4,        0, 0, "seq_4");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h8,        0, 0, "seq_8");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'hc,        0, 0, "seq_c");
    // Two sources at once: source 0 wins.
    cyc(0, 2'b11, 32'h100,      32'h200,      0, 32'h100,      1, 0, "both_src");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h104,      0, 0, "after_redir");
    // Four-cycle stall with mixed-priority arrivals.
    cyc(1, 2'b10, 32'h0,        32'h200,      0, 32'h104,      0, 0, "stall_c1");
    cyc(1, 2'b00, 32'h0,        32'h0,        0, 32'h104,      0, 0, "stall_c2");
    cyc(1, 2'b01, 32'h300,      32'h0,        0, 32'h104,      0, 0, "stall_c3");
    cyc(1, 2'b10, 32'h0,        32'h400,      0, 32'h104,      0, 0, "stall_c4");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h300,      1, 0, "stall_release");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h304,      0, 0, "post_release");
    // Same-source newer redirect replaces the pending one.
    cyc(1, 2'b10, 32'h0,        32'h200,      0, 32'h304,      0, 0, "same_src_a");
    cyc(1, 2'b10, 32'h0,        32'h240,      0, 32'h304,      0, 0, "same_src_b");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h240,      1, 0, "same_src_rel");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h244,      0, 0, "same_src_next");
    // Pending source 0 beats a live source 1 on release.
    cyc(1, 2'b01, 32'h500,      32'h0,        0, 32'h244,      0, 0, "pend_hi");
    cyc(0, 2'b10, 32'h0,        32'h600,      0, 32'h500,      1, 0, "pend_beats_live");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h504,      0, 0, "pend_next");
    // Single low-priority source, then a stall right after a redirect.
    cyc(0, 2'b10, 32'h0,        32'h700,      0, 32'h700,      1, 0, "src1_only");
    cyc(1, 2'b00, 32'h0,        32'h0,        0, 32'h700,      0, 0, "stall_after_redir");
    // Reset with a pending redirect and a live one: both discarded.
    cyc(1, 2'b01, 32'h800,      32'h0,        0, 32'h700,      0, 0, "pend_before_rst");
    cyc(0, 2'b01, 32'h900,      32'h0,        1, 32'h0,        0, 0, "rst_with_redir");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h4,        0, 0, "rst_cleared_pend");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h8,        0, 0, "rst_seq_8");
    // Address wrap.
    cyc(0, 2'b01, 32'hffff_fffc, 32'h0,       0, 32'hffff_fffc, 1, 0, "wrap_redir");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h0,        0, 0, "wrap_zero");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h4,        0, 0, "wrap_four");
`ifdef PC_GEN_BTB_EN
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h8,        0, 0, "btb_upd_taken",
        1'b1, 32'h10, 32'h80, 1'b1);
    cyc(0, 2'b01, 32'h10,       32'h0,        0, 32'h10,       1, 1, "btb_hit");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h80,       0, 0, "btb_pred_target");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h84,       0, 0, "btb_after_target");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h88,       0, 0, "btb_upd_nt",
        1'b1, 32'h10, 32'h80, 1'b0);
    cyc(0, 2'b01, 32'h10,       32'h0,        0, 32'h10,       1, 0, "btb_evicted");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h14,       0, 0, "btb_evict_seq");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h18,       0, 0, "btb_reinstall",
        1'b1, 32'h10, 32'h80, 1'b1);
    cyc(0, 2'b01, 32'h50,       32'h0,        0, 32'h50,       1, 0, "btb_alias_miss");
    cyc(0, 2'b00, 32'h0,        32'h0,        0, 32'h54,       0, 0, "btb_alias_seq");
`endif

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
